// File: rtl/prog_loader.sv
// Framed byte-stream loader: writes N big-endian 16-bit words to memory from address 0, holding the CPU meanwhile.
// Optional trailing XOR checksum byte when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Start,
  input  logic [7:0]        RxData,
  input  logic              RxValid,
  output logic              RxReady,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] MemAddrOut,
  output logic [DATA_W-1:0] MemDataOut,
  output logic              CpuHold,
  output logic              Done,
  output logic              Error
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_CNT_HI  = 4'd1,
    S_CNT_LO  = 4'd2,
    S_WORD_HI = 4'd3,
    S_WORD_LO = 4'd4,
    S_WRITE   = 4'd5,
    S_DONE    = 4'd6,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_ERROR   = 4'd7,
    S_CHECK   = 4'd8
`else
    S_ERROR   = 4'd7
`endif
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [7:0]        hi_q, hi_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              rx_ready_s;
  logic              accept_s;
  logic [15:0]       cnt_full_s;
  logic [15:0]       idx_inc_s;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  assign rx_ready_s = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                      (state_q == S_WORD_HI) || (state_q == S_WORD_LO)
`ifdef PROG_LOADER_CHECKSUM_EN
                      || (state_q == S_CHECK)
`endif
                      ;
  assign accept_s   = RxValid && rx_ready_s;
  assign cnt_full_s = {cnt_q[15:8], RxData};
  assign idx_inc_s  = 16'(idx_q) + 16'd1;

  // Next-state and datapath update for the loader FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    data_d  = data_q;
    hold_d  = hold_q;
    done_d  = done_q;
    error_d = error_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    if (accept_s && (state_q != S_CHECK)) begin
      csum_d = csum_fold(csum_q, RxData);
    end else begin
      csum_d = csum_q;
    end
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (Start) begin
          state_d = S_CNT_HI;
          idx_d   = '0;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end else begin
          state_d = state_q;
        end
      end
      S_CNT_HI: begin
        if (accept_s) begin
          cnt_d   = {RxData, 8'h00};
          state_d = S_CNT_LO;
        end else begin
          state_d = state_q;
        end
      end
      S_CNT_LO: begin
        if (accept_s) begin
          cnt_d = cnt_full_s;
          if ({1'b0, cnt_full_s} > MAX_WORDS) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else if (cnt_full_s == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_DONE;
            hold_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = S_WORD_HI;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_WORD_HI: begin
        if (accept_s) begin
          hi_d    = RxData;
          state_d = S_WORD_LO;
        end else begin
          state_d = state_q;
        end
      end
      S_WORD_LO: begin
        if (accept_s) begin
          data_d  = {hi_q, RxData};
          state_d = S_WRITE;
        end else begin
          state_d = state_q;
        end
      end
      S_WRITE: begin
        // index is one wider than the address so N = 2^ADDR_W finishes without wrapping
        idx_d = idx_q + 1'b1;
        if (idx_inc_s < cnt_q) begin
          state_d = S_WORD_HI;
        end else begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
          hold_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept_s) begin
          if (RxData == csum_q) begin
            state_d = S_DONE;
            hold_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= '0;
      hi_q    <= 8'h00;
      data_q  <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      error_q <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hi_q    <= hi_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      error_q <= error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign RxReady    = rx_ready_s;
  assign MemWrite   = (state_q == S_WRITE);
  assign MemAddrOut = idx_q[ADDR_W-1:0];
  assign MemDataOut = data_q;
  assign CpuHold    = hold_q;
  assign Done       = done_q;
  assign Error      = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; follows PROG_LOADER_CHECKSUM_EN for trailer bytes.
module tb_prog_loader;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Start;
  logic [7:0]  RxData;
  logic        RxValid;
  logic        RxReady;
  logic        MemWrite;
  logic [9:0]  MemAddrOut;
  logic [15:0] MemDataOut;
  logic        CpuHold;
  logic        Done;
  logic        Error;

  int total = 0;
  int bad = 0;
  int overlap = 0;
  logic [9:0]  w_addr[$];
  logic [15:0] w_data[$];
  logic [7:0]  tb_csum;

  prog_loader #(.ADDR_W(10), .DATA_W(16)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .RxData(RxData), .RxValid(RxValid),
    .RxReady(RxReady), .MemWrite(MemWrite), .MemAddrOut(MemAddrOut),
    .MemDataOut(MemDataOut), .CpuHold(CpuHold), .Done(Done), .Error(Error)
  );

  always #5 CLK = ~CLK;

  // Capture every memory write seen at a rising edge
  always @(posedge CLK) begin
    if (MemWrite) begin
      w_addr.push_back(MemAddrOut);
      w_data.push_back(MemDataOut);
      if (RxReady) overlap++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_load();
    w_addr.delete();
    w_data.delete();
    tb_csum = 8'h00;
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    ok = 1'b0;
    if (gap) begin
      RxValid = 1'b0;
      tick();
    end
    RxData  = b;
    RxValid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (RxReady) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    RxValid = 1'b0;
    tb_csum = tb_csum ^ b;
    if (!ok) check_val("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_trailer(input bit gap);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(tb_csum, gap);
`else
    if (gap) tick();
`endif
  endtask

  task automatic wait_end();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (Done || Error) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check_val("end_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_rdy"},   32'(RxReady),    32'd0);
    check_val({tag, "_wr"},    32'(MemWrite),   32'd0);
    check_val({tag, "_addr"},  32'(MemAddrOut), 32'd0);
    check_val({tag, "_data"},  32'(MemDataOut), 32'd0);
    check_val({tag, "_hold"},  32'(CpuHold),    32'd1);
    check_val({tag, "_done"},  32'(Done),       32'd0);
    check_val({tag, "_error"}, 32'(Error),      32'd0);
  endtask

  task automatic check_two_word_image(input string tag);
    check_val({tag, "_nwr"}, 32'(w_addr.size()), 32'd2);
    if (w_addr.size() == 2) begin
      check_val({tag, "_a0"}, 32'(w_addr[0]), 32'd0);
      check_val({tag, "_d0"}, 32'(w_data[0]), 32'h1234);
      check_val({tag, "_a1"}, 32'(w_addr[1]), 32'd1);
      check_val({tag, "_d1"}, 32'(w_data[1]), 32'hABCD);
    end
    check_val({tag, "_done"}, 32'(Done),    32'd1);
    check_val({tag, "_hold"}, 32'(CpuHold), 32'd0);
    check_val({tag, "_err"},  32'(Error),   32'd0);
  endtask

  initial begin
    logic [7:0] img [6];
    img[0] = 8'h00; img[1] = 8'h02; img[2] = 8'h12;
    img[3] = 8'h34; img[4] = 8'hAB; img[5] = 8'hCD;
    Reset = 1'b1; Start = 1'b0; RxData = 8'h00; RxValid = 1'b0;
    tick();
    check_reset_values("rst");
    Reset = 1'b0;
    tick();

    // Back-to-back two-word image
    start_load();
    for (int i = 0; i < 6; i++) send_byte(img[i], 1'b0);
    send_trailer(1'b0);
    wait_end();
    check_two_word_image("b2b");

    // Same image with a gap before every byte
    start_load();
    for (int i = 0; i < 6; i++) send_byte(img[i], 1'b1);
    send_trailer(1'b1);
    wait_end();
    check_two_word_image("gap");
    check_val("wr_rdy_overlap", 32'(overlap), 32'd0);

    // Oversize count 0x0401
    start_load();
    send_byte(8'h04, 1'b0);
    send_byte(8'h01, 1'b0);
    tick();
    check_val("big_err",  32'(Error),         32'd1);
    check_val("big_done", 32'(Done),          32'd0);
    check_val("big_hold", 32'(CpuHold),       32'd1);
    check_val("big_rdy",  32'(RxReady),       32'd0);
    check_val("big_nwr",  32'(w_addr.size()), 32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // Wrong checksum trailer
    start_load();
    send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b0);
    wait_end();
    check_val("cs_nwr", 32'(w_addr.size()), 32'd1);
    if (w_addr.size() == 1) check_val("cs_d0", 32'(w_data[0]), 32'h0005);
    check_val("cs_err",  32'(Error), 32'd1);
    check_val("cs_done", 32'(Done),  32'd0);
`endif

    // Reset in the middle of a frame, then a fresh image
    start_load();
    send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h12, 1'b0);
    RxData = 8'h34; RxValid = 1'b1; Reset = 1'b1;
    #2;
    check_reset_values("mid_rst");
    RxValid = 1'b0;
    tick();
    Reset = 1'b0;
    tick();
    start_load();
    send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'hFF, 1'b0); send_byte(8'hFF, 1'b0);
    send_trailer(1'b0);
    wait_end();
    check_val("rl_nwr", 32'(w_addr.size()), 32'd1);
    if (w_addr.size() == 1) begin
      check_val("rl_a0", 32'(w_addr[0]), 32'd0);
      check_val("rl_d0", 32'(w_data[0]), 32'hFFFF);
    end
    check_val("rl_done", 32'(Done), 32'd1);

    // Empty image from DONE
    start_load();
    check_val("empty_hold_on", 32'(CpuHold), 32'd1);
    check_val("empty_done_clr", 32'(Done),   32'd0);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    send_trailer(1'b0);
    wait_end();
    check_val("empty_done", 32'(Done),          32'd1);
    check_val("empty_hold", 32'(CpuHold),       32'd0);
    check_val("empty_nwr",  32'(w_addr.size()), 32'd0);

    // Full-size image of 1024 words, word i = i
    start_load();
    send_byte(8'h04, 1'b0); send_byte(8'h00, 1'b0);
    for (int i = 0; i < 1024; i++) begin
      send_byte(8'(i >> 8), 1'b0);
      send_byte(8'(i), 1'b0);
    end
    send_trailer(1'b0);
    wait_end();
    check_val("full_nwr",  32'(w_addr.size()), 32'd1024);
    if (w_addr.size() == 1024) begin
      check_val("full_a_last", 32'(w_addr[1023]), 32'd1023);
      check_val("full_d_last", 32'(w_data[1023]), 32'd1023);
      check_val("full_a_first", 32'(w_addr[0]), 32'd0);
    end
    check_val("full_done", 32'(Done),  32'd1);
    check_val("full_err",  32'(Error), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
